// File: rtl/appliance_setting_bank.sv
// Bank of NCH clamped setting channels with a run/lock
// programme countdown loaded from the timer channel.
module appliance_setting_bank #(
  parameter int WIDTH    = 5,
  parameter int NCH      = 4,
  parameter int SELW     = 2,
  parameter int TIMER_CH = 3,
  parameter int MAX_VAL  = 2**WIDTH-1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SELW-1:0]        sel,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       inp,
  input  logic                   tick,
  input  logic                   start,
  input  logic                   stop,
  output logic [NCH*WIDTH-1:0]   settings,
  output logic [WIDTH-1:0]       remaining,
  output logic                   running,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CEIL  = WIDTH'(MAX_VAL);
  localparam logic [SELW:0]    NCH_L = (SELW+1)'(NCH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] ch [NCH];
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] tval;
  logic [WIDTH-1:0] wdata;
  logic             sel_ok;
  logic             locked;
  logic             wr_ok;
  logic             wr_bad;
  logic             start_ok;
  logic             start_bad;
  logic             err_nx;

  // Request qualification: stop swallows every other request,
  // writes lock during RUN, start samples the pre-write timer.
  always_comb begin
    tval      = ch[TIMER_CH];
    locked    = (state == RUN);
    sel_ok    = ({1'b0, sel} < NCH_L);
    wdata     = (inp > CEIL) ? CEIL : inp;
    wr_ok     = wr_en & sel_ok & ~locked & ~stop;
    wr_bad    = wr_en & ~(sel_ok & ~locked) & ~stop;
    start_ok  = start & ~locked & ~stop & (tval != '0);
    start_bad = start & ~locked & ~stop & (tval == '0);
    err_nx    = wr_bad | start_bad;
  end

  // Next state and next countdown value.
  always_comb begin
    state_nx = state;
    rem_nx   = remaining;
    if (stop) begin
      state_nx = IDLE;
      rem_nx   = '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state_nx = RUN;
            rem_nx   = tval;
          end
        end
        RUN: begin
          if (tick) begin
            if (remaining > WIDTH'(1)) begin
              rem_nx = remaining - WIDTH'(1);
            end else begin
              rem_nx   = '0;
              state_nx = DONE;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          rem_nx   = '0;
        end
      endcase
    end
  end

  // State, countdown and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= rem_nx;
      running   <= (state_nx == RUN);
      done      <= (state_nx == DONE);
      err       <= err_nx;
    end
  end

  // Channel storage; one clamped write per cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (rst) begin
        ch[k] <= '0;
      end else if (wr_ok && sel == SELW'(k)) begin
        ch[k] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_flat
    assign settings[g*WIDTH +: WIDTH] = ch[g];
  end

endmodule

// File: tb/tb_appliance_setting_bank.sv
// Random and directed bench for appliance_setting_bank;
// a rule-level model tracks a default and a 3-channel instance.
module tb_appliance_setting_bank;

  logic        clk = 1'b0;
  logic        rst, wr_en, tick, start, stop;
  logic [1:0]  sel;
  logic [4:0]  inp;
  logic [19:0] settings;
  logic [4:0]  remaining;
  logic        running, done, err;
  logic [14:0] settings2;
  logic [4:0]  remaining2;
  logic        running2, done2, err2;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  int mch  [2][4];
  int mrem [2];
  int mst  [2];
  int merr [2];
  int mnch [2] = '{4, 3};
  int mmax [2] = '{31, 20};
  int mtim [2] = '{3, 2};

  always #5 clk = ~clk;

  appliance_setting_bank dut (
    .clk(clk), .rst(rst), .sel(sel), .wr_en(wr_en), .inp(inp),
    .tick(tick), .start(start), .stop(stop),
    .settings(settings), .remaining(remaining),
    .running(running), .done(done), .err(err)
  );

  appliance_setting_bank #(
    .NCH(3), .TIMER_CH(2), .MAX_VAL(20)
  ) dut2 (
    .clk(clk), .rst(rst), .sel(sel), .wr_en(wr_en), .inp(inp),
    .tick(tick), .start(start), .stop(stop),
    .settings(settings2), .remaining(remaining2),
    .running(running2), .done(done2), .err(err2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Model: 0=IDLE 1=RUN 2=DONE, following the written rules.
  task automatic mstep(input int i);
    int s0, t, e;
    if (rst) begin
      for (int k = 0; k < 4; k++) mch[i][k] = 0;
      mrem[i] = 0; mst[i] = 0; merr[i] = 0;
    end else if (stop) begin
      mrem[i] = 0; mst[i] = 0; merr[i] = 0;
    end else begin
      s0 = mst[i];
      t  = mch[i][mtim[i]];
      e  = 0;
      if (wr_en) begin
        if (int'(sel) < mnch[i] && s0 != 1)
          mch[i][sel] = (int'(inp) > mmax[i]) ? mmax[i] : int'(inp);
        else
          e = 1;
      end
      if (s0 != 1 && start) begin
        if (t == 0) e = 1;
        else begin mrem[i] = t; mst[i] = 1; end
      end else if (s0 == 1 && tick) begin
        if (mrem[i] > 0) mrem[i] = mrem[i] - 1;
        if (mrem[i] == 0) mst[i] = 2;
      end
      merr[i] = e;
    end
  endtask

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end

  function automatic int pack(input int i);
    int v = 0;
    for (int k = 0; k < mnch[i]; k++) v += mch[i][k] << (5*k);
    return v;
  endfunction

  // Every cycle after reset: both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("settings",   int'(settings),   pack(0));
      chk("remaining",  int'(remaining),  mrem[0]);
      chk("running",    int'(running),    int'(mst[0] == 1));
      chk("done",       int'(done),       int'(mst[0] == 2));
      chk("err",        int'(err),        merr[0]);
      chk("settings2",  int'(settings2),  pack(1));
      chk("remaining2", int'(remaining2), mrem[1]);
      chk("running2",   int'(running2),   int'(mst[1] == 1));
      chk("done2",      int'(done2),      int'(mst[1] == 2));
      chk("err2",       int'(err2),       merr[1]);
    end
  end

  task automatic drv(input bit r, input bit w, input int s, input int d,
                     input bit tk, input bit st, input bit sp);
    rst = r; wr_en = w; sel = 2'(s); inp = 5'(d);
    tick = tk; start = st; stop = sp;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0);
    armed = 1'b1;
    drv(1, 0, 0, 0, 0, 0, 0);
    chk("rst_settings", int'(settings), 0);
    chk("rst_running",  int'(running),  0);

    drv(0, 1, 0, 31, 0, 0, 0);
    drv(0, 1, 1, 21, 0, 0, 0);
    chk("ch1_clamp20", int'(settings2[9:5]), 20);
    drv(0, 1, 2, 10, 0, 0, 0);
    drv(0, 1, 3, 23, 0, 0, 0);
    chk("pack_lit", int'(settings), int'({5'd23, 5'd10, 5'd21, 5'd31}));
    chk("no_err",   int'(err), 0);
    chk("sel3_err", int'(err2), 1);
    idle(1);
    chk("sel3_err_one", int'(err2), 0);
    chk("sel3_keep", int'(settings2), int'({5'd10, 5'd20, 5'd20}));

    drv(0, 1, 3, 3, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("run_after_start", int'(running), 1);
    chk("rem_load", int'(remaining), 3);
    for (int n = 2; n >= 0; n--) begin
      idle(3);
      drv(0, 0, 0, 0, 1, 0, 0);
      chk("rem_tick", int'(remaining), n);
    end
    chk("done_set", int'(done), 1);
    chk("run_clr", int'(running), 0);
    idle(2);
    chk("done_hold", int'(done), 1);

    drv(0, 1, 3, 5, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("rem5", int'(remaining), 5);
    drv(0, 1, 0, 7, 0, 0, 0);
    chk("lock_err", int'(err), 1);
    chk("lock_ch0", int'(settings[4:0]), 31);
    drv(0, 0, 0, 0, 0, 1, 1);
    chk("stop_run", int'(running), 0);
    chk("stop_rem", int'(remaining), 0);
    chk("stop_done", int'(done), 0);

    drv(0, 1, 3, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("start0_err", int'(err), 1);
    chk("start0_idle", int'(running), 0);
    drv(0, 1, 3, 4, 0, 1, 0);
    chk("wr_start_err", int'(err), 1);
    chk("wr_start_ch3", int'(settings[19:15]), 4);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("rem4", int'(remaining), 4);
    chk("run4", int'(running), 1);
    drv(0, 0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    chk("rem2", int'(remaining), 2);
    drv(1, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_set", int'(settings), 0);
    chk("rst_mid_done", int'(done), 0);
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 1, 0, 0);
      chk("no_done", int'(done), 0);
    end

    for (int i = 0; i < 4000; i++) begin
      drv($urandom_range(99) < 1, $urandom_range(99) < 40,
          $urandom_range(3), $urandom_range(31),
          $urandom_range(99) < 30, $urandom_range(99) < 10,
          $urandom_range(99) < 4);
    end
    idle(1);
    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
